// File: rtl/reg_select_encoder_if.sv
// Handshake bundle for reg_select_encoder.
// Carries the select-vector input side and the register-index output side.
interface reg_select_encoder_if;
    logic [7:0] in;
    logic       in_valid;
    logic       in_ready;
    logic       out_ready;
    logic [2:0] register;
    logic       out_valid;
    logic       last;
    logic       onehot;
    logic [3:0] count;
    logic       empty;

    modport master (
        output in,
        output in_valid,
        input  in_ready,
        output out_ready,
        input  register,
        input  out_valid,
        input  last,
        input  onehot,
        input  count,
        input  empty
    );

    modport slave (
        input  in,
        input  in_valid,
        output in_ready,
        input  out_ready,
        output register,
        output out_valid,
        output last,
        output onehot,
        output count,
        output empty
    );
endinterface

// File: rtl/reg_select_encoder.sv
// Drains a multi-hot register-select vector into 3-bit indices,
// lowest register number first, one index per accepted beat.
module reg_select_encoder (
    input  logic             clock,
    input  logic             reset,
    reg_select_encoder_if.slave bus
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [7:0] pending_q;
    logic [7:0] pending_d;
    logic [3:0] count_q;
    logic [3:0] count_d;
    logic       onehot_q;
    logic       onehot_d;
    logic       empty_q;
    logic       empty_d;

    logic [2:0] head_idx;
    logic [7:0] head_mask;
    logic       head_last;
    logic [3:0] in_pop;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] s;
        s = 4'd0;
        for (int i = 0; i < 8; i++) begin
            s = s + {3'd0, v[i]};
        end
        return s;
    endfunction

    // Head of the pending set: highest set bit is the lowest register.
    always_comb begin
        head_idx = 3'd0;
        for (int b = 0; b < 8; b++) begin
            if (pending_q[b]) begin
                head_idx = 3'(7 - b);
            end
        end
        head_mask = 8'h80 >> head_idx;
        head_last = (pending_q != 8'd0)
                 && ((pending_q & (pending_q - 8'd1)) == 8'd0);
    end

    assign in_pop = popcount8(bus.in);

    // Next-state and capture/drain bookkeeping.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        count_d   = count_q;
        onehot_d  = onehot_q;
        empty_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    pending_d = bus.in;
                    count_d   = in_pop;
                    onehot_d  = (in_pop == 4'd1);
                    if (bus.in != 8'd0) begin
                        state_d = DRAIN;
                    end else begin
                        empty_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (bus.out_ready) begin
                    pending_d = pending_q & ~head_mask;
                    if (head_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset discards any partially drained vector.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= 8'd0;
            count_q   <= 4'd0;
            onehot_q  <= 1'b0;
            empty_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            count_q   <= count_d;
            onehot_q  <= onehot_d;
            empty_q   <= empty_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DRAIN);
    assign bus.register  = head_idx;
    assign bus.last      = head_last && (state_q == DRAIN);
    assign bus.onehot    = onehot_q;
    assign bus.count     = count_q;
    assign bus.empty     = empty_q;

endmodule

// File: tb/tb_reg_select_encoder.sv
// Directed bench for reg_select_encoder.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_reg_select_encoder;

    logic clock;
    logic reset;
    int   total;
    int   fails;

    reg_select_encoder_if bus ();

    reg_select_encoder dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic capture(input logic [7:0] v);
        bus.in       = v;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.in       = 8'd0;
    endtask

    initial begin
        logic [7:0] v;
        total         = 0;
        fails         = 0;
        reset         = 1'b1;
        bus.in        = 8'd0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        step();
        step();
        reset = 1'b0;
        step();
        chk("rst_in_ready", 8'(bus.in_ready), 8'd1);
        chk("rst_out_valid", 8'(bus.out_valid), 8'd0);
        chk("rst_count", 8'(bus.count), 8'd0);
        chk("rst_empty", 8'(bus.empty), 8'd0);
        chk("rst_onehot", 8'(bus.onehot), 8'd0);
        chk("rst_last", 8'(bus.last), 8'd0);

        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            v = 8'h80 >> i;
            capture(v);
            chk("oh_valid", 8'(bus.out_valid), 8'd1);
            chk("oh_reg", 8'(bus.register), 8'(i));
            chk("oh_last", 8'(bus.last), 8'd1);
            chk("oh_onehot", 8'(bus.onehot), 8'd1);
            chk("oh_count", 8'(bus.count), 8'd1);
            chk("oh_busy", 8'(bus.in_ready), 8'd0);
            step();
            chk("oh_ready_back", 8'(bus.in_ready), 8'd1);
            chk("oh_valid_drop", 8'(bus.out_valid), 8'd0);
        end

        capture(8'b0010_0100);
        chk("mh_count", 8'(bus.count), 8'd2);
        chk("mh_onehot", 8'(bus.onehot), 8'd0);
        chk("mh_reg0", 8'(bus.register), 8'd2);
        chk("mh_last0", 8'(bus.last), 8'd0);
        step();
        chk("mh_reg1", 8'(bus.register), 8'd5);
        chk("mh_last1", 8'(bus.last), 8'd1);
        step();
        chk("mh_idle", 8'(bus.in_ready), 8'd1);

        capture(8'hFF);
        chk("ff_count", 8'(bus.count), 8'd8);
        for (int k = 0; k < 8; k++) begin
            chk("ff_valid", 8'(bus.out_valid), 8'd1);
            chk("ff_reg", 8'(bus.register), 8'(k));
            chk("ff_last", 8'(bus.last), (k == 7) ? 8'd1 : 8'd0);
            step();
        end
        chk("ff_idle", 8'(bus.in_ready), 8'd1);
        chk("ff_done", 8'(bus.out_valid), 8'd0);

        bus.out_ready = 1'b0;
        capture(8'b0100_0010);
        for (int c = 0; c < 3; c++) begin
            chk("bp_reg", 8'(bus.register), 8'd1);
            chk("bp_last", 8'(bus.last), 8'd0);
            chk("bp_busy", 8'(bus.in_ready), 8'd0);
            bus.in       = 8'hFF;
            bus.in_valid = (c != 1);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.in        = 8'd0;
        chk("bp_hold_reg", 8'(bus.register), 8'd1);
        chk("bp_count", 8'(bus.count), 8'd2);
        bus.out_ready = 1'b1;
        step();
        chk("bp_reg1", 8'(bus.register), 8'd6);
        chk("bp_last1", 8'(bus.last), 8'd1);
        step();
        chk("bp_idle", 8'(bus.in_ready), 8'd1);
        chk("bp_count_kept", 8'(bus.count), 8'd2);

        capture(8'h00);
        chk("z_empty", 8'(bus.empty), 8'd1);
        chk("z_valid", 8'(bus.out_valid), 8'd0);
        chk("z_count", 8'(bus.count), 8'd0);
        chk("z_onehot", 8'(bus.onehot), 8'd0);
        chk("z_ready", 8'(bus.in_ready), 8'd1);
        capture(8'b0001_0000);
        chk("z_empty_gone", 8'(bus.empty), 8'd0);
        chk("z_next_valid", 8'(bus.out_valid), 8'd1);
        chk("z_next_reg", 8'(bus.register), 8'd3);
        step();
        chk("z_next_idle", 8'(bus.in_ready), 8'd1);

        capture(8'hF0);
        chk("rm_reg0", 8'(bus.register), 8'd0);
        step();
        chk("rm_reg1", 8'(bus.register), 8'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rm_valid", 8'(bus.out_valid), 8'd0);
        chk("rm_ready", 8'(bus.in_ready), 8'd1);
        capture(8'b0000_0011);
        chk("rm_count", 8'(bus.count), 8'd2);
        chk("rm_reg6", 8'(bus.register), 8'd6);
        chk("rm_last6", 8'(bus.last), 8'd0);
        step();
        chk("rm_reg7", 8'(bus.register), 8'd7);
        chk("rm_last7", 8'(bus.last), 8'd1);
        step();
        chk("rm_done", 8'(bus.out_valid), 8'd0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/reg_select_encoder.md
# reg_select_encoder

Sequential encoder that converts an 8-bit register-select vector (bit 7 = r0 … bit 0 = r7, the same one-hot mapping the register-file select decoder produces) back into 3-bit register indices. A multi-hot vector is accepted through a valid/ready handshake and drained one index per accepted output beat, lowest register number first. It sits between control logic that produces register-select masks (multi-register moves, save/restore sequences) and datapath stages that consume a single 3-bit register field per cycle.

## Interface
- No parameters; widths fixed at 8-bit select vector, 3-bit index.
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in  input  8  register-select vector; bit 7 = r0, bit 6 = r1, …, bit 0 = r7
- in_valid  input  1  `in` holds a vector to be encoded
- in_ready  output  1  block can capture a vector this cycle
- out_ready  input  1  consumer accepts `register` this cycle
- register  output  3  encoded register index (0 = r0 … 7 = r7)
- out_valid  output  1  `register` is valid
- last  output  1  current `register` is the final index of the captured vector
- onehot  output  1  captured vector had exactly one bit set
- count  output  4  number of set bits in the captured vector (0–8)
- empty  output  1  one-cycle pulse: an all-zero vector was captured

## Operation
- State machine: IDLE, DRAIN. A `pending[7:0]` register holds the bits not yet emitted.
- IDLE: `in_ready` = 1, `out_valid` = 0.
  - Capture occurs on `in_valid` & `in_ready`. On capture: `pending` <= `in`; `count` <= popcount(`in`); `onehot` <= (popcount == 1).
  - If `in` != 0: go to DRAIN.
  - If `in` == 0: `empty` pulses high for the next cycle only; stay in IDLE; `count` = 0, `onehot` = 0.
- DRAIN: `in_ready` = 0; `in_valid` and `in` are ignored.
  - `out_valid` = 1.
  - `register` = index of the highest set bit of `pending`, i.e. the lowest register number. Bit b maps to register 7−b.
  - `last` = 1 when `pending` has exactly one bit set.
  - On `out_valid` & `out_ready`: clear the emitted bit in `pending`. If `last` was set, go to IDLE.
  - Without `out_ready`: `register`, `last` and `pending` hold stable.
- `count` and `onehot` hold their capture-time values until the next capture. `count` does not decrement while draining.
- All outputs are derived from registered state only. There is no combinational path from `in`, `in_valid` or `out_ready` to any output.
- Reset, at any point including mid-drain: `pending` = 0, state IDLE, the partially drained vector is discarded.

## Timing
- Reset values, first cycle after reset: `in_ready` = 1, `out_valid` = 0, `register` = 0, `last` = 0, `onehot` = 0, `count` = 0, `empty` = 0.
- Capture at edge N → `out_valid` = 1 with the first index in cycle N+1.
- Throughput: one index per cycle while `out_ready` is held high. A vector with k set bits drains in k cycles minimum.
- Final handshake at edge M → `in_ready` = 1 in cycle M+1. There is no overlap between draining and capturing the next vector.
- Zero-vector capture at edge N → `empty` = 1 in cycle N+1 only, `in_ready` stays 1, and a new vector can be captured at edge N+1.
- `register` outside DRAIN is don't-care. The bench checks it only while `out_valid` = 1.

## Test plan
- **Reset defaults:** assert `reset` for 2 cycles, then release → `in_ready` = 1, `out_valid` = 0, `count` = 0, `empty` = 0, `onehot` = 0.
- **All one-hot values:** capture each of the 8 one-hot vectors, with `out_ready` = 1 → exactly one beat each. 8'b10000000 → 0, 8'b00000001 → 7, `last` = 1, `onehot` = 1, `count` = 1; `in_ready` returns the cycle after the beat.
- **Multi-hot ordering:** capture 8'b00100100 → `count` = 2, `onehot` = 0, beats `register` = 2 (`last` = 0) then 5 (`last` = 1). Capture 8'hFF → indices 0..7 on 8 consecutive cycles.
- **Backpressure and ignored input:** capture 8'b01000010, hold `out_ready` = 0 for 3 cycles → `register` = 1 stable, `last` = 0. Toggle `in_valid` with 8'hFF during this time → ignored. Release `out_ready` → beats 1, 6.
- **Zero vector:** capture 8'h00 → `empty` = 1 for exactly one cycle, no `out_valid`, `count` = 0. Capture 8'b00010000 on the next cycle → `register` = 3.
- **Reset mid-drain:** capture 8'hF0 and accept 2 beats (0, 1), then assert `reset` → next cycle `out_valid` = 0, `in_ready` = 1. A subsequent capture of 8'b00000011 yields 6, 7 only.
